ddr2_v10_1_sequencer_cpu_ocimem_ctrl: RTL and testbench

//  Debug on-chip memory controller sitting directly downstream of the sequencer CPU JTAG debug module.

---
 rtl/ddr2_v10_1_sequencer_ocimem_pkg.sv | 22 ++
 rtl/ddr2_v10_1_sequencer_ocimem_ram.sv | 26 ++
 rtl/ddr2_v10_1_sequencer_cpu_ocimem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ddr2_v10_1_sequencer_cpu_ocimem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_v10_1_sequencer_ocimem_pkg.sv
// Shared definitions for the sequencer CPU debug on-chip memory controller:
// jdo field positions and the controller state encoding.
package ddr2_v10_1_sequencer_ocimem_pkg;

    localparam int JDO_W         = 38;
    localparam int WORD_W        = 32;
    localparam int JADDR_W       = 16;

    // jdo command/data field positions
    localparam int LOAD_ADDR_BIT = 35;
    localparam int RD_REQ_BIT    = 34;
    localparam int CLR_ERR_BIT   = 33;
    localparam int ADDR_LSB      = 17;
    localparam int WDATA_LSB     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JRD  = 2'd1,
        CRD  = 2'd2
    } ocimem_state_e;

endpackage

// File: rtl/ddr2_v10_1_sequencer_ocimem_ram.sv
// Single-port synchronous debug RAM, one access per cycle, 1-cycle read latency.
// Contents are not reset.
module ddr2_v10_1_sequencer_ocimem_ram
    import ddr2_v10_1_sequencer_ocimem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write-enable store plus registered read of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/ddr2_v10_1_sequencer_cpu_ocimem_ctrl.sv
// Debug on-chip memory controller behind the sequencer CPU JTAG debug module.
// JTAG strobes and the CPU Avalon-MM slave share one single-port RAM; JTAG
// always wins, the CPU is stalled with waitrequest and retries.
module ddr2_v10_1_sequencer_cpu_ocimem_ctrl
    import ddr2_v10_1_sequencer_ocimem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [WORD_W-1:0] avs_writedata,
    output logic [WORD_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [WORD_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [ADDR_W-1:0] mon_a_inc;

    logic [JADDR_W-1:0] jdo_addr;
    logic               addr_bad;
    logic               sel_a, sel_b, sel_n;
    logic               any_strobe, multi_strobe;
    logic               jtag_rd, cpu_wr, cpu_rd;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_q;

    // Command bits 37:36 and 2:0 carry nothing for this block
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[JDO_W-1:LOAD_ADDR_BIT+1], jdo[WDATA_LSB-1:0]};

    assign jdo_addr  = jdo[ADDR_LSB +: JADDR_W];
    assign mon_a_inc = (mon_a_reg == ADDR_W'(DEPTH - 1)) ? '0 : mon_a_reg + ADDR_W'(1);

    // Strobe priority, address check and RAM port arbitration (JTAG over CPU)
    always_comb begin
        sel_a        = take_action_ocimem_a;
        sel_b        = take_action_ocimem_b & ~take_action_ocimem_a;
        sel_n        = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
        any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
        addr_bad     = jdo[LOAD_ADDR_BIT] &&
                       ({1'b0, jdo_addr} >= (JADDR_W+1)'(DEPTH));

        ram_addr  = mon_a_reg;
        ram_we    = 1'b0;
        ram_wdata = jdo[WDATA_LSB +: WORD_W];
        jtag_rd   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;

        if (state == IDLE) begin
            if (sel_a) begin
                // A freshly loaded address is used by a read in the same command
                if (jdo[LOAD_ADDR_BIT] && !addr_bad) begin
                    ram_addr = jdo_addr[ADDR_W-1:0];
                end
                jtag_rd = jdo[RD_REQ_BIT] && !addr_bad;
            end else if (sel_b) begin
                ram_we = 1'b1;
            end else if (sel_n) begin
                jtag_rd = 1'b1;
            end else if (avs_write) begin
                cpu_wr    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = avs_address;
                ram_wdata = avs_writedata;
            end else if (avs_read) begin
                cpu_rd   = 1'b1;
                ram_addr = avs_address;
            end
        end
    end

    // CPU handshake: stalled except for an accepted write or the CRD data cycle
    always_comb begin
        avs_waitrequest = 1'b1;
        if (reset_n && ((state == CRD) || cpu_wr)) begin
            avs_waitrequest = 1'b0;
        end
        avs_readdata = (state == CRD) ? ram_q : '0;
    end

    ddr2_v10_1_sequencer_ocimem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // Controller FSM with the JTAG-visible address/data/status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_a) begin
                        if (jdo[CLR_ERR_BIT]) begin
                            monitor_error <= 1'b0;
                        end
                        if (addr_bad) begin
                            monitor_error <= 1'b1;
                        end else if (jdo[LOAD_ADDR_BIT]) begin
                            mon_a_reg <= jdo_addr[ADDR_W-1:0];
                        end
                        monitor_ready <= 1'b0;
                        if (jtag_rd) begin
                            state <= JRD;
                        end
                    end else if (sel_b) begin
                        mon_a_reg     <= mon_a_inc;
                        monitor_ready <= 1'b1;
                    end else if (sel_n) begin
                        mon_a_reg     <= mon_a_inc;
                        monitor_ready <= 1'b0;
                        state         <= JRD;
                    end else if (cpu_rd) begin
                        state <= CRD;
                    end
                    // Dropped strobes override any error clear in the same cycle
                    if (multi_strobe) begin
                        monitor_error <= 1'b1;
                    end
                end
                JRD: begin
                    MonDReg       <= ram_q;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                end
                CRD: begin
                    state <= IDLE;
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_v10_1_sequencer_cpu_ocimem_ctrl.sv
// Scoreboard bench for the debug on-chip memory controller: stimulus pushes
// expected JTAG completions and CPU read data, a negedge monitor pops and compares.
module tb_ddr2_v10_1_sequencer_cpu_ocimem_ctrl;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        logic        err;
    } jexp_t;

    jexp_t       jq[$];
    logic [31:0] cq[$];
    int          ncmp  = 0;
    int          nfail = 0;
    logic        prev_rdy = 1'b0;

    ddr2_v10_1_sequencer_cpu_ocimem_ctrl #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic ld, input logic rd, input logic clr,
                                         input logic [15:0] addr);
        return {2'b00, ld, rd, clr, addr, 17'd0};
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        return {3'b000, data, 3'b000};
    endfunction

    task automatic push_wr();
        jexp_t e;
        e.is_rd = 1'b0; e.data = '0; e.err = 1'b0;
        jq.push_back(e);
    endtask

    task automatic push_rd(input logic [31:0] d);
        jexp_t e;
        e.is_rd = 1'b1; e.data = d; e.err = 1'b0;
        jq.push_back(e);
    endtask

    task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: JTAG completion on monitor_ready rising, CPU data on read && !waitrequest
    always @(negedge clk) begin
        jexp_t e;
        if (reset_n) begin
            if (monitor_ready && !prev_rdy) begin
                if (jq.size() == 0) begin
                    chk("jtag_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = jq.pop_front();
                    if (e.is_rd) chk("jtag_rd_data", MonDReg, e.data);
                    chk("jtag_done_err", {31'd0, monitor_error}, {31'd0, e.err});
                end
            end
            if (avs_read && !avs_waitrequest) begin
                if (cq.size() == 0) begin
                    chk("cpu_unexpected_rdata", 32'd1, 32'd0);
                end else begin
                    chk("cpu_rd_data", avs_readdata, cq.pop_front());
                end
            end
        end
        prev_rdy = monitor_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b1;
        avs_writedata = 32'h0;

        // Reset values, with a CPU write pending to prove waitrequest is held
        @(negedge clk);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
        chk("rst_error", {31'd0, monitor_error}, 32'd0);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
        avs_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // 1: load 0x10, write DEADBEEF, read back with 2-cycle latency
        pulse(1, 0, 0, mk_a(1, 0, 0, 16'h0010));
        push_wr();
        pulse(0, 1, 0, mk_b(32'hDEADBEEF));
        pulse(1, 0, 0, mk_a(1, 0, 0, 16'h0000));
        push_rd(32'hDEADBEEF);
        pulse(1, 0, 0, mk_a(1, 1, 0, 16'h0010));
        @(negedge clk);
        chk("t1_ready_n1", {31'd0, monitor_ready}, 32'd0);
        @(negedge clk);
        chk("t1_ready_n2", {31'd0, monitor_ready}, 32'd1);

        // 2: streaming reads across the top of memory
        pulse(1, 0, 0, mk_a(1, 0, 0, 16'h00FF));
        push_wr();
        pulse(0, 1, 0, mk_b(32'hA5A500FF));
        pulse(0, 1, 0, mk_b(32'h0BADF00D));
        pulse(1, 0, 0, mk_a(1, 0, 0, 16'h00FF));
        push_rd(32'hA5A500FF);
        pulse(0, 0, 1, '0);
        idle(1);
        push_rd(32'h0BADF00D);
        pulse(0, 0, 1, '0);
        idle(2);
        @(negedge clk);
        chk("t2_wrap_no_err", {31'd0, monitor_error}, 32'd0);

        // 3: out-of-range address flags error and leaves MonAReg alone
        pulse(1, 0, 0, mk_a(1, 0, 0, 16'h0100));
        @(negedge clk);
        chk("t3_bad_addr_err", {31'd0, monitor_error}, 32'd1);
        pulse(1, 0, 0, mk_a(0, 0, 1, 16'h0000));
        @(negedge clk);
        chk("t3_err_cleared", {31'd0, monitor_error}, 32'd0);
        push_wr();
        pulse(0, 1, 0, mk_b(32'h600D0001));
        push_rd(32'h600D0001);
        pulse(1, 0, 0, mk_a(1, 1, 0, 16'h0001));
        idle(2);

        // 4: CPU write collides with a JTAG write and is stalled one cycle
        pulse(1, 0, 0, mk_a(1, 0, 0, 16'h0020));
        push_wr();
        jdo = mk_b(32'hCAFEF00D);
        take_action_ocimem_b = 1'b1;
        avs_write = 1'b1;
        avs_address = 8'd5;
        avs_writedata = 32'h12345678;
        @(negedge clk);
        chk("t4_cpu_wr_blocked", {31'd0, avs_waitrequest}, 32'd1);
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("t4_cpu_wr_accept", {31'd0, avs_waitrequest}, 32'd0);
        @(posedge clk); #1;
        avs_write = 1'b0;
        push_rd(32'hCAFEF00D);
        pulse(1, 0, 0, mk_a(1, 1, 0, 16'h0020));
        idle(2);

        // 5: CPU read of addr 5, with a JTAG strobe landing in the CRD cycle
        cq.push_back(32'h12345678);
        avs_read = 1'b1;
        avs_address = 8'd5;
        @(negedge clk);
        chk("t5_grant_wait", {31'd0, avs_waitrequest}, 32'd1);
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        avs_read = 1'b0;
        @(negedge clk);
        chk("t5_strobe_in_crd_err", {31'd0, monitor_error}, 32'd1);
        chk("t5_strobe_dropped_ready", {31'd0, monitor_ready}, 32'd1);
        pulse(1, 0, 0, mk_a(0, 0, 1, 16'h0000));
        push_rd(32'hCAFEF00D);
        pulse(0, 0, 1, '0);
        idle(2);

        // 6: asynchronous reset while a JTAG read is in JRD
        pulse(1, 0, 0, mk_a(1, 0, 0, 16'h0100));
        pulse(1, 0, 0, mk_a(1, 1, 0, 16'h0010));
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_MonDReg", MonDReg, 32'h0);
        chk("t6_ready", {31'd0, monitor_ready}, 32'd0);
        chk("t6_error", {31'd0, monitor_error}, 32'd0);
        chk("t6_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
        chk("t6_readdata", avs_readdata, 32'h0);
        idle(2);
        @(negedge clk);
        reset_n = 1'b1;
        avs_write = 1'b1;
        avs_address = 8'd7;
        avs_writedata = 32'h00000007;
        #1;
        chk("t6_idle_after_reset", {31'd0, avs_waitrequest}, 32'd0);
        @(posedge clk); #1;
        avs_write = 1'b0;
        idle(3);

        chk("jtag_queue_drained", jq.size(), 32'd0);
        chk("cpu_queue_drained", cq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
